// File: rtl/lcd_host_ctrl_if.sv
// lcd_host_ctrl_if: upstream op, image ROM, LCD controller and window-read signals of lcd_host_ctrl
interface lcd_host_ctrl_if;
    logic        op_valid, op_ready, cmd_valid, output_valid, busy, done, err;
    logic [2:0]  op, cmd;
    logic [6:0]  img_addr;
    logic [7:0]  img_data, datain, dataout, win_pixel;
    logic [3:0]  win_addr;
    logic [11:0] win_sum;
    logic [1:0]  err_code;
    modport master (
        output op_valid, op, img_data, dataout, output_valid, busy, win_addr,
        input  op_ready, img_addr, cmd, cmd_valid, datain, win_pixel, win_sum, done, err, err_code
    );
    modport slave (
        input  op_valid, op, img_data, dataout, output_valid, busy, win_addr,
        output op_ready, img_addr, cmd, cmd_valid, datain, win_pixel, win_sum, done, err, err_code
    );
endinterface

// File: rtl/lcd_host_ctrl.sv
// lcd_host_ctrl: issues one LCD command per op, streams the image ROM on load and captures the 4x4 output window
module lcd_host_ctrl #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input logic            clk,
    input logic            reset,
    lcd_host_ctrl_if.slave bus
);
    localparam logic [2:0] IDLE = 3'd0, ISSUE = 3'd1, LOAD = 3'd2, WAIT_BUSY = 3'd3, COLLECT = 3'd4, WAIT_IDLE = 3'd5;
    logic [2:0] state;
    logic [7:0] wd;
    logic [3:0] cnt;
    logic [7:0] pix [16];
    logic       accept, cap, last, timeout;
    assign bus.op_ready  = state == IDLE && !bus.busy;
    assign bus.datain    = bus.img_data;
    assign bus.win_pixel = pix[bus.win_addr];
    assign accept        = bus.op_valid && bus.op_ready;
    // a beat may arrive in the very cycle busy first rises
    assign cap           = bus.output_valid && (state == COLLECT || (state == WAIT_BUSY && bus.busy));
    assign last          = cap && cnt == 4'd15;
    assign timeout       = state != IDLE && wd == TIMEOUT - 8'd1;
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            wd            <= 8'd0;
            cnt           <= 4'd0;
            bus.cmd       <= 3'd0;
            bus.cmd_valid <= 1'b0;
            bus.img_addr  <= 7'd0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
            bus.err_code  <= 2'd0;
            bus.win_sum   <= 12'd0;
            for (int i = 0; i < 16; i++) pix[i] <= 8'd0;
        end else begin
            bus.cmd_valid <= 1'b0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
            wd            <= state == IDLE ? 8'd0 : wd + 8'd1;
            if (cap) begin
                pix[cnt]    <= bus.dataout;
                bus.win_sum <= bus.win_sum + 12'(bus.dataout);
                cnt         <= cnt + 4'd1;
            end
            if (timeout) begin
                state        <= IDLE;
                bus.err      <= 1'b1;
                bus.err_code <= 2'd2;
            end else begin
                case (state)
                    IDLE: if (accept) begin
                        if (bus.op == 3'd7) begin
                            bus.err      <= 1'b1;
                            bus.err_code <= 2'd1;
                        end else begin
                            state         <= ISSUE;
                            bus.cmd       <= bus.op;
                            bus.cmd_valid <= 1'b1;
                            bus.img_addr  <= 7'd0;
                            bus.win_sum   <= 12'd0;
                            cnt           <= 4'd0;
                        end
                    end
                    ISSUE: begin
                        state        <= bus.cmd == 3'd0 ? LOAD : WAIT_BUSY;
                        bus.img_addr <= bus.cmd == 3'd0 ? 7'd1 : 7'd0;
                    end
                    // wd counts from ISSUE, so 108 marks the last streaming cycle
                    LOAD: begin
                        bus.img_addr <= bus.img_addr == 7'd107 ? 7'd107 : bus.img_addr + 7'd1;
                        if (wd == 8'd108) state <= WAIT_BUSY;
                    end
                    WAIT_BUSY: state <= last ? WAIT_IDLE : bus.busy ? COLLECT : WAIT_BUSY;
                    COLLECT: if (last) state <= WAIT_IDLE;
                    WAIT_IDLE: if (!bus.busy) begin
                        bus.done <= 1'b1;
                        state    <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_lcd_host_ctrl.sv
// tb_lcd_host_ctrl: random ops against ROM and LCD controller models, scoreboarded done/err events and window contents
module tb_lcd_host_ctrl;
    timeunit 1ns;
    timeprecision 10ps;
    typedef struct {
        bit                is_err;
        int                code;
        int                sum;
        int                at;
        logic [15:0][7:0]  pix;
    } exp_t;
    logic clk = 1'b0;
    logic reset;
    int cyc = 0;
    int n_chk = 0, n_pass = 0;
    bit mute = 1'b0;
    logic [7:0] rom [128];
    logic [7:0] lcd_img [108];
    logic [7:0] ref_img [108];
    logic [7:0] ref_buf [16];
    logic [7:0] seen [16];
    int ref_sum = 0;
    bit mode_in = 1'b0;
    int row = 3, col = 4;
    exp_t sb [$];
    lcd_host_ctrl_if bus ();
    lcd_host_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) bus.img_data <= rom[bus.img_addr];
    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask
    // image index of window pixel i under the current LCD geometry
    function automatic int win_idx(input int i);
        return mode_in ? (row + i / 4) * 12 + col + i % 4 : (1 + 2 * (i / 4)) * 12 + 1 + 3 * (i % 4);
    endfunction
    // LCD controller model
    initial begin
        logic [2:0] c;
        bus.busy = 1'b0;
        bus.output_valid = 1'b0;
        bus.dataout = 8'd0;
        forever begin
            @(posedge clk); #1;
            if (bus.cmd_valid && !mute && !reset) begin
                c = bus.cmd;
                @(posedge clk); #1;
                bus.busy = 1'b1;
                if (c == 3'd0)
                    for (int k = 0; k < 108 && !reset; k++) begin
                        lcd_img[k] = bus.datain;
                        @(posedge clk); #1;
                    end
                if (!reset)
                    for (int i = 0; i < 16; i++) begin
                        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                        bus.dataout = lcd_img[win_idx(i)];
                        bus.output_valid = 1'b1;
                        bus.busy = i != 15;
                        @(posedge clk); #1;
                        bus.output_valid = 1'b0;
                    end
                bus.busy = 1'b0;
                if (!reset && $urandom_range(0, 1) == 1) begin
                    bus.dataout = 8'($urandom);
                    bus.output_valid = 1'b1;
                    @(posedge clk); #1;
                    bus.output_valid = 1'b0;
                end
            end
        end
    end
    // scoreboard monitor
    initial begin
        exp_t e;
        int bad;
        bus.win_addr = 4'd0;
        forever begin
            @(negedge clk);
            if (bus.cmd_valid) chk("cmd_while_busy", int'(bus.busy), 0);
            if (!reset && (bus.done || bus.err)) begin
                if (sb.size() == 0) chk("unexpected_event", int'({bus.done, bus.err}), 0);
                else begin
                    e = sb.pop_front();
                    chk("event_kind", int'({bus.done, bus.err}), e.is_err ? 1 : 2);
                    if (e.is_err) chk("err_code", int'(bus.err_code), e.code);
                    if (e.at >= 0) chk("event_cycle", cyc, e.at);
                    chk("win_sum", int'(bus.win_sum), e.sum);
                    chk("ready_at_event", int'(bus.op_ready), 1);
                    bad = 0;
                    for (int i = 0; i < 16; i++) begin
                        bus.win_addr = 4'(i);
                        #0.2;
                        seen[i] = bus.win_pixel;
                        if (bus.win_pixel != e.pix[i]) bad++;
                    end
                    chk("window_pixels_wrong", bad, 0);
                end
            end
        end
    end
    task automatic wait_ready();
        int n = 0;
        @(posedge clk); #2;
        while (!bus.op_ready && n < 2000) begin @(posedge clk); #2; n++; end
        chk("op_ready_wait", int'(bus.op_ready), 1);
    endtask
    task automatic do_op(input logic [2:0] o, input bit m);
        exp_t e;
        int a, n, bad;
        mute = m;
        wait_ready();
        a = cyc;
        if (o != 3'd7) begin
            ref_sum = 0;
            if (!m) begin
                case (o)
                    3'd0: begin
                        for (int i = 0; i < 108; i++) ref_img[i] = rom[i];
                        mode_in = 1'b0; row = 3; col = 4;
                    end
                    3'd1: mode_in = 1'b1;
                    3'd2: mode_in = 1'b0;
                    3'd3: if (mode_in && col < 8) col++;
                    3'd4: if (mode_in && col > 0) col--;
                    3'd5: if (mode_in && row > 0) row--;
                    default: if (mode_in && row < 5) row++;
                endcase
                for (int i = 0; i < 16; i++) begin
                    ref_buf[i] = ref_img[win_idx(i)];
                    ref_sum += int'(ref_buf[i]);
                end
            end
        end
        e.is_err = o == 3'd7 || m;
        e.code = o == 3'd7 ? 1 : 2;
        e.at = o == 3'd7 ? a + 1 : m ? a + 256 : -1;
        e.sum = ref_sum;
        for (int i = 0; i < 16; i++) e.pix[i] = ref_buf[i];
        sb.push_back(e);
        bus.op_valid = 1'b1;
        bus.op = o;
        @(posedge clk); #2;
        bus.op_valid = 1'b0;
        @(negedge clk);
        chk("cmd_valid_A1", int'(bus.cmd_valid), int'(o != 3'd7));
        if (o != 3'd7) begin
            chk("cmd_A1", int'(bus.cmd), int'(o));
            chk("img_addr_A1", int'(bus.img_addr), 0);
        end else chk("ready_after_illegal", int'(bus.op_ready), 1);
        @(negedge clk);
        chk("cmd_valid_A2", int'(bus.cmd_valid), 0);
        if (o == 3'd0) begin
            bad = 0;
            for (int k = 0; k < 108; k++) begin
                if (k > 0) @(negedge clk);
                if (bus.datain != rom[k]) bad++;
                if (int'(bus.img_addr) != (k < 107 ? k + 1 : 107)) bad++;
            end
            chk("load_stream_errors", bad, 0);
        end
        n = 0;
        while (sb.size() != 0 && n < 2000) begin @(posedge clk); #2; n++; end
        chk("completion_pending", sb.size(), 0);
        sb.delete();
    endtask
    initial begin
        #1200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int a;
        logic [2:0] o;
        reset = 1'b1;
        bus.op_valid = 1'b0;
        bus.op = 3'd0;
        for (int i = 0; i < 128; i++) rom[i] = 8'(i);
        for (int i = 0; i < 16; i++) ref_buf[i] = 8'd0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("rst_cmd_valid", int'(bus.cmd_valid), 0);
        chk("rst_cmd", int'(bus.cmd), 0);
        chk("rst_img_addr", int'(bus.img_addr), 0);
        chk("rst_done_err", int'({bus.done, bus.err}), 0);
        chk("rst_err_code", int'(bus.err_code), 0);
        chk("rst_win_sum", int'(bus.win_sum), 0);
        chk("rst_op_ready", int'(bus.op_ready), 1);
        chk("rst_pixel", int'(bus.win_pixel), 0);
        do_op(3'd0, 1'b0);
        chk("load_sum", int'(bus.win_sum), 856);
        chk("load_pix0", int'(seen[0]), 13);
        chk("load_pix15", int'(seen[15]), 94);
        do_op(3'd2, 1'b0);
        chk("fit_sum", int'(bus.win_sum), 856);
        chk("fit_pix4", int'(seen[4]), 37);
        do_op(3'd1, 1'b0);
        chk("zoom_sum", int'(bus.win_sum), 952);
        chk("zoom_pix0", int'(seen[0]), 40);
        chk("zoom_pix15", int'(seen[15]), 79);
        do_op(3'd3, 1'b0);
        chk("right_sum", int'(bus.win_sum), 968);
        chk("right_pix0", int'(seen[0]), 41);
        do_op(3'd7, 1'b0);
        chk("illegal_code_hold", int'(bus.err_code), 1);
        chk("illegal_sum_kept", int'(bus.win_sum), 968);
        do_op(3'd4, 1'b1);
        chk("timeout_code_hold", int'(bus.err_code), 2);
        chk("timeout_sum", int'(bus.win_sum), 0);
        chk("timeout_pix0_kept", int'(seen[0]), 41);
        mute = 1'b0;
        wait_ready();
        bus.op_valid = 1'b1;
        bus.op = 3'd0;
        a = cyc;
        @(posedge clk); #2;
        bus.op_valid = 1'b0;
        while (cyc < a + 51) begin @(posedge clk); #2; end
        @(negedge clk);
        chk("load50_img_addr", int'(bus.img_addr), 50);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_img_addr", int'(bus.img_addr), 0);
        chk("midrst_cmd_valid", int'(bus.cmd_valid), 0);
        chk("midrst_win_sum", int'(bus.win_sum), 0);
        chk("midrst_err_code", int'(bus.err_code), 0);
        chk("midrst_pixel", int'(bus.win_pixel), 0);
        @(posedge clk); #2;
        reset = 1'b0;
        ref_sum = 0;
        for (int i = 0; i < 16; i++) ref_buf[i] = 8'd0;
        wait_ready();
        for (int i = 0; i < 108; i++) rom[i] = 8'($urandom);
        do_op(3'd0, 1'b0);
        for (int t = 0; t < 24; t++) begin
            o = 3'($urandom_range(0, 7));
            if (o == 3'd0) for (int i = 0; i < 108; i++) rom[i] = 8'($urandom);
            do_op(o, o != 3'd7 && $urandom_range(0, 7) == 0);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
